// File: rtl/f2sdram_term_pkg.sv
// Shared types for the f2sdram safe terminator: FSM state encoding and counter sizing.
// Pure declarations; no logic, no timing.
package f2sdram_term_pkg;

    typedef enum logic [2:0] {
        PASS,
        CMD_HOLD,
        WR_FLUSH,
        RD_DRAIN,
        HALT
    } state_t;

    // Outstanding-beat counter must hold MAX_OUT_BEATS itself, hence the extra bit.
    function automatic int cnt_w(input int max_out_beats);
        return $clog2(max_out_beats) + 1;
    endfunction

endpackage

// File: rtl/f2sdram_beat_tracker.sv
// Remaining write-burst beats and outstanding read beats, plus the read-admission compare.
// Counters update one cycle after the accepted command/beat; rd_stall is combinational.
module f2sdram_beat_tracker
    import f2sdram_term_pkg::*;
#(
    parameter int BURST_W       = 8,
    parameter int MAX_OUT_BEATS = 256,
    parameter int CNT_W         = cnt_w(MAX_OUT_BEATS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic [BURST_W-1:0] m_burstcount,
    input  logic               wr_acc,
    input  logic               rd_acc,
    input  logic               rd_beat,
    input  logic               s_read,
    input  logic [BURST_W-1:0] s_burstcount,
    output logic               rd_stall,
    output logic [BURST_W-1:0] wr_left_d,
    output logic [CNT_W-1:0]   out_beats_d,
    output logic [CNT_W-1:0]   out_beats_q
);

    logic [BURST_W-1:0] wr_left_q;
    logic [CNT_W:0]     beat_sum;

    function automatic logic [BURST_W-1:0] eff_bc(input logic [BURST_W-1:0] bc);
        return (bc == '0) ? BURST_W'(1) : bc;
    endfunction

    assign rd_stall = s_read &&
        (({1'b0, out_beats_q} + (CNT_W+1)'(eff_bc(s_burstcount))) > (CNT_W+1)'(MAX_OUT_BEATS));

    always_comb begin
        wr_left_d = wr_left_q;
        if (clear) begin
            wr_left_d = '0;
        end else if (wr_acc) begin
            if (wr_left_q == '0) begin
                wr_left_d = eff_bc(m_burstcount) - 1'b1;
            end else begin
                wr_left_d = wr_left_q - 1'b1;
            end
        end
    end

    always_comb begin
        beat_sum = {1'b0, out_beats_q} + (rd_acc ? (CNT_W+1)'(eff_bc(m_burstcount)) : '0);
        // A beat with nothing outstanding is spurious and must not wrap the count.
        if (rd_beat && (beat_sum != '0)) begin
            beat_sum = beat_sum - 1'b1;
        end
        if (clear) begin
            out_beats_d = '0;
        end else if (beat_sum[CNT_W]) begin
            out_beats_d = '1;
        end else begin
            out_beats_d = beat_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_left_q   <= '0;
            out_beats_q <= '0;
        end else begin
            wr_left_q   <= wr_left_d;
            out_beats_q <= out_beats_d;
        end
    end

endmodule

// File: rtl/f2sdram_safe_terminator_mc.sv
// Avalon-MM safe terminator between a core master and one HPS f2sdram port.
// Zero-latency pass-through in PASS; on rst_req it finishes every in-flight burst, then parks in HALT.
module f2sdram_safe_terminator_mc
    import f2sdram_term_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter int ADDR_W        = 29,
    parameter int BURST_W       = 8,
    parameter int MAX_OUT_BEATS = 256,
    parameter int TIMEOUT_CYC   = 65535,
    parameter int BE_W          = DATA_W / 8,
    parameter int CNT_W         = cnt_w(MAX_OUT_BEATS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rst_req,
    input  logic [ADDR_W-1:0]  s_address,
    input  logic [BURST_W-1:0] s_burstcount,
    input  logic               s_read,
    input  logic               s_write,
    input  logic [DATA_W-1:0]  s_writedata,
    input  logic [BE_W-1:0]    s_byteenable,
    output logic               s_waitrequest,
    output logic [DATA_W-1:0]  s_readdata,
    output logic               s_readdatavalid,
    output logic [ADDR_W-1:0]  m_address,
    output logic [BURST_W-1:0] m_burstcount,
    output logic               m_read,
    output logic               m_write,
    output logic [DATA_W-1:0]  m_writedata,
    output logic [BE_W-1:0]    m_byteenable,
    input  logic               m_waitrequest,
    input  logic [DATA_W-1:0]  m_readdata,
    input  logic               m_readdatavalid,
    output logic               idle,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   out_beats
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    state_t             state_q, state_d, after_cmd;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               timeout_err_q, timeout_err_d;
    logic [ADDR_W-1:0]  hold_addr_q, hold_addr_d;
    logic [BURST_W-1:0] hold_bc_q, hold_bc_d;
    logic               hold_rd_q, hold_rd_d;
    logic               hold_wr_q, hold_wr_d;
    logic [DATA_W-1:0]  hold_wdat_q, hold_wdat_d;
    logic [BE_W-1:0]    hold_be_q, hold_be_d;

    logic               rd_stall;
    logic               cmd_stalled;
    logic               counting;
    logic               wd_expire;
    logic [BURST_W-1:0] wr_left_d;
    logic [CNT_W-1:0]   out_beats_d;

    f2sdram_beat_tracker #(
        .BURST_W       (BURST_W),
        .MAX_OUT_BEATS (MAX_OUT_BEATS),
        .CNT_W         (CNT_W)
    ) u_tracker (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (wd_expire),
        .m_burstcount  (m_burstcount),
        .wr_acc        (m_write && !m_waitrequest),
        .rd_acc        (m_read && !m_waitrequest),
        .rd_beat       (m_readdatavalid),
        .s_read        (s_read),
        .s_burstcount  (s_burstcount),
        .rd_stall      (rd_stall),
        .wr_left_d     (wr_left_d),
        .out_beats_d   (out_beats_d),
        .out_beats_q   (out_beats)
    );

    assign counting    = (state_q == CMD_HOLD) || (state_q == WR_FLUSH) || (state_q == RD_DRAIN);
    assign wd_expire   = counting && (wd_q == WD_LAST);
    assign cmd_stalled = (m_read || m_write) && m_waitrequest;
    assign idle        = (state_q == HALT);
    assign timeout_err = timeout_err_q;
    assign s_readdata  = m_readdata;

    // Master-side drive and slave-side handshake.
    always_comb begin
        m_address       = hold_addr_q;
        m_burstcount    = hold_bc_q;
        m_read          = 1'b0;
        m_write         = 1'b0;
        m_writedata     = hold_wdat_q;
        m_byteenable    = hold_be_q;
        s_waitrequest   = 1'b1;
        s_readdatavalid = 1'b0;
        case (state_q)
            PASS: begin
                m_address    = s_address;
                m_burstcount = s_burstcount;
                m_read       = s_read && !rd_stall;
                m_write      = s_write;
                m_writedata  = s_writedata;
                m_byteenable = s_byteenable;
                // The rst_req cycle keeps the master side stable but hides it from the core.
                if (!rst_req) begin
                    s_waitrequest   = m_waitrequest || rd_stall;
                    s_readdatavalid = m_readdatavalid;
                end
            end
            CMD_HOLD: begin
                m_read  = hold_rd_q;
                m_write = hold_wr_q;
            end
            WR_FLUSH: begin
                m_write      = 1'b1;
                m_writedata  = '0;
                m_byteenable = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        timeout_err_d = timeout_err_q;
        hold_addr_d   = hold_addr_q;
        hold_bc_d     = hold_bc_q;
        hold_rd_d     = hold_rd_q;
        hold_wr_d     = hold_wr_q;
        hold_wdat_d   = hold_wdat_q;
        hold_be_d     = hold_be_q;
        after_cmd     = HALT;

        if (wr_left_d != '0) begin
            after_cmd = WR_FLUSH;
        end else if (out_beats_d != '0) begin
            after_cmd = RD_DRAIN;
        end

        case (state_q)
            PASS: begin
                if (rst_req) begin
                    hold_addr_d = m_address;
                    hold_bc_d   = m_burstcount;
                    hold_rd_d   = m_read;
                    hold_wr_d   = m_write;
                    hold_wdat_d = m_writedata;
                    hold_be_d   = m_byteenable;
                    state_d     = cmd_stalled ? CMD_HOLD : after_cmd;
                end
            end
            CMD_HOLD: begin
                if (!m_waitrequest) begin
                    state_d = after_cmd;
                end
            end
            WR_FLUSH: begin
                if (wr_left_d == '0) begin
                    state_d = (out_beats_d != '0) ? RD_DRAIN : HALT;
                end
            end
            RD_DRAIN: begin
                if (out_beats_d == '0) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (!rst_req) begin
                    state_d = PASS;
                end
            end
            default: state_d = PASS;
        endcase

        if (wd_expire) begin
            timeout_err_d = 1'b1;
            state_d       = HALT;
        end

        wd_d = (counting && (state_d == state_q)) ? wd_q + WD_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= PASS;
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
            hold_addr_q   <= '0;
            hold_bc_q     <= '0;
            hold_rd_q     <= 1'b0;
            hold_wr_q     <= 1'b0;
            hold_wdat_q   <= '0;
            hold_be_q     <= '0;
        end else begin
            state_q       <= state_d;
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
            hold_addr_q   <= hold_addr_d;
            hold_bc_q     <= hold_bc_d;
            hold_rd_q     <= hold_rd_d;
            hold_wr_q     <= hold_wr_d;
            hold_wdat_q   <= hold_wdat_d;
            hold_be_q     <= hold_be_d;
        end
    end

endmodule

// File: tb/tb_f2sdram_safe_terminator_mc.sv
// Directed and randomised checks of the f2sdram safe terminator against a beat-count model.
module tb_f2sdram_safe_terminator_mc;
    import f2sdram_term_pkg::*;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 29;
    localparam int BURST_W = 8;
    localparam int MAX_OUT = 256;
    localparam int TMO     = 100;
    localparam int BE_W    = DATA_W / 8;
    localparam int CNT_W   = cnt_w(MAX_OUT);

    logic               clk = 1'b0;
    logic               reset_n;
    logic               rst_req;
    logic [ADDR_W-1:0]  s_address;
    logic [BURST_W-1:0] s_burstcount;
    logic               s_read;
    logic               s_write;
    logic [DATA_W-1:0]  s_writedata;
    logic [BE_W-1:0]    s_byteenable;
    logic               s_waitrequest;
    logic [DATA_W-1:0]  s_readdata;
    logic               s_readdatavalid;
    logic [ADDR_W-1:0]  m_address;
    logic [BURST_W-1:0] m_burstcount;
    logic               m_read;
    logic               m_write;
    logic [DATA_W-1:0]  m_writedata;
    logic [BE_W-1:0]    m_byteenable;
    logic               m_waitrequest;
    logic [DATA_W-1:0]  m_readdata;
    logic               m_readdatavalid;
    logic               idle;
    logic               timeout_err;
    logic [CNT_W-1:0]   out_beats;

    int errors = 0;
    int checks = 0;
    int mdl_out = 0;
    int mdl_wr = 0;
    logic last_rd_acc;

    f2sdram_safe_terminator_mc #(
        .DATA_W        (DATA_W),
        .ADDR_W        (ADDR_W),
        .BURST_W       (BURST_W),
        .MAX_OUT_BEATS (MAX_OUT),
        .TIMEOUT_CYC   (TMO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rst_req         (rst_req),
        .s_address       (s_address),
        .s_burstcount    (s_burstcount),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_byteenable    (s_byteenable),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .m_address       (m_address),
        .m_burstcount    (m_burstcount),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .idle            (idle),
        .timeout_err     (timeout_err),
        .out_beats       (out_beats)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // One PASS-state cycle: check the pass-through against the model, then advance the model.
    task automatic pass_cyc();
        int   bc;
        logic stall;
        settle();
        bc    = (s_burstcount == '0) ? 1 : int'(s_burstcount);
        stall = s_read && (mdl_out + bc > MAX_OUT);
        chk("pass_m_read", m_read, s_read && !stall);
        chk("pass_s_wait", s_waitrequest, m_waitrequest || stall);
        chk("pass_s_rdv", s_readdatavalid, m_readdatavalid);
        if (m_readdatavalid) chk("pass_s_rdata", s_readdata, m_readdata);
        if (s_read || s_write) chk("pass_m_addr", m_address, s_address);
        if (s_write) chk("pass_m_wdata", m_writedata, s_writedata);
        last_rd_acc = s_read && !stall && !m_waitrequest;
        if (s_write && !m_waitrequest) mdl_wr = (mdl_wr == 0) ? bc - 1 : mdl_wr - 1;
        if (last_rd_acc) mdl_out += bc;
        if (m_readdatavalid && mdl_out > 0) mdl_out--;
        tick();
        chk("pass_out_beats", out_beats, mdl_out);
    endtask

    // Raise rst_req with the core idle and HPS returning data; count flushed write beats.
    task automatic terminate(input int exp_flush);
        int flushed = 0;
        int bad = 0;
        int leaks = 0;
        int n = 0;
        s_read = 1'b0; s_write = 1'b0; m_waitrequest = 1'b0; m_readdatavalid = 1'b0;
        rst_req = 1'b1;
        settle();
        chk("term_req_cycle_wait", s_waitrequest, 1'b1);
        tick();
        while (!idle && n < 300) begin
            m_waitrequest   = ($urandom_range(0, 2) == 0);
            m_readdatavalid = 1'b1;
            m_readdata      = {$urandom, $urandom};
            settle();
            if (m_write && !m_waitrequest) flushed++;
            if (m_write && (m_byteenable != '0 || m_writedata != '0)) bad++;
            if (m_read || s_readdatavalid || !s_waitrequest) leaks++;
            tick();
            n++;
        end
        m_readdatavalid = 1'b0;
        m_waitrequest   = 1'b0;
        chk("term_flush_beats", flushed, exp_flush);
        chk("term_flush_be_zero", bad, 0);
        chk("term_no_leak", leaks, 0);
        chk("term_idle", idle, 1'b1);
        chk("term_out_beats", out_beats, 0);
        chk("term_no_timeout", timeout_err, 1'b0);
        rst_req = 1'b0;
        tick();
        chk("term_back_to_pass", idle, 1'b0);
        mdl_out = 0;
        mdl_wr  = 0;
    endtask

    initial begin
        logic [ADDR_W-1:0] held_addr;
        int n;
        int stalled;

        reset_n = 1'b0; rst_req = 1'b0;
        s_address = '0; s_burstcount = '0; s_read = 1'b0; s_write = 1'b0;
        s_writedata = '0; s_byteenable = '0;
        m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
        tick();
        tick();
        chk("rst_idle", idle, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        chk("rst_out_beats", out_beats, 0);
        chk("rst_m_read", m_read, 1'b0);
        chk("rst_m_write", m_write, 1'b0);
        chk("rst_s_rdv", s_readdatavalid, 1'b0);
        reset_n = 1'b1;
        tick();

        // Read burst of 8, data returned unchanged.
        s_address = ADDR_W'($urandom); s_burstcount = 8'd8; s_read = 1'b1;
        pass_cyc();
        chk("t1_out_8", out_beats, 8);
        s_read = 1'b0;
        repeat (8) begin
            m_readdatavalid = 1'b1; m_readdata = {$urandom, $urandom};
            pass_cyc();
        end
        m_readdatavalid = 1'b0;
        chk("t1_out_0", out_beats, 0);

        // Outstanding cap: two bursts of 128 fill it, a third waits for room.
        s_burstcount = 8'd128; s_read = 1'b1;
        pass_cyc();
        pass_cyc();
        chk("t2_out_full", out_beats, 256);
        n = 0; stalled = 0; last_rd_acc = 1'b0;
        m_readdatavalid = 1'b1;
        while (!last_rd_acc && n < 300) begin
            m_readdata = {$urandom, $urandom};
            settle();
            if (s_waitrequest) stalled++;
            pass_cyc();
            n++;
        end
        chk("t2_stall_cycles", stalled, 128);
        s_read = 1'b0; n = 0;
        while (mdl_out > 0 && n < 400) begin
            pass_cyc();
            n++;
        end
        m_readdatavalid = 1'b0;
        chk("t2_drained", out_beats, 0);

        // Read stalled by HPS when rst_req arrives: held, then drained.
        s_address = ADDR_W'($urandom); s_burstcount = 8'd4; s_read = 1'b1; m_waitrequest = 1'b1;
        repeat (10) pass_cyc();
        held_addr = s_address;
        rst_req = 1'b1;
        settle();
        chk("t4_req_wait", s_waitrequest, 1'b1);
        chk("t4_req_m_read", m_read, 1'b1);
        tick();
        s_read = 1'b0; s_address = ~held_addr; s_burstcount = 8'd7;
        repeat (3) begin
            settle();
            chk("t4_hold_read", m_read, 1'b1);
            chk("t4_hold_addr", m_address, held_addr);
            chk("t4_hold_bc", m_burstcount, 4);
            chk("t4_hold_wait", s_waitrequest, 1'b1);
            tick();
        end
        m_waitrequest = 1'b0;
        tick();
        chk("t4_out_4", out_beats, 4);
        rst_req = 1'b0;
        repeat (4) begin
            m_readdatavalid = 1'b1; m_readdata = {$urandom, $urandom};
            settle();
            chk("t4_drain_no_read", m_read, 1'b0);
            chk("t4_drain_discard", s_readdatavalid, 1'b0);
            tick();
        end
        m_readdatavalid = 1'b0;
        chk("t4_halt", idle, 1'b1);
        chk("t4_halt_out", out_beats, 0);
        tick();
        chk("t4_pass_again", idle, 1'b0);

        // Randomised pass-through traffic, then a termination.
        mdl_out = 0; mdl_wr = 0;
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 3);
            s_read  = (r == 1);
            s_write = (r == 2);
            s_burstcount = s_read ? BURST_W'($urandom_range(0, 16)) : BURST_W'($urandom_range(1, 32));
            s_address = ADDR_W'($urandom);
            s_writedata = {$urandom, $urandom};
            s_byteenable = BE_W'($urandom);
            m_waitrequest = ($urandom_range(0, 3) == 0);
            m_readdatavalid = ($urandom_range(0, 1) == 1);
            m_readdata = {$urandom, $urandom};
            pass_cyc();
        end
        s_read = 1'b0; s_write = 1'b0; m_waitrequest = 1'b0; m_readdatavalid = 1'b1; n = 0;
        while (mdl_out > 20 && n < 600) begin
            pass_cyc();
            n++;
        end
        m_readdatavalid = 1'b0;
        terminate(mdl_wr);

        // Write burst of 16 interrupted after beat 5: 11 flush beats.
        s_address = ADDR_W'($urandom); s_burstcount = 8'd16; s_write = 1'b1;
        repeat (5) begin
            s_writedata = {$urandom, $urandom}; s_byteenable = '1;
            pass_cyc();
        end
        terminate(11);

        // HPS never returns data: watchdog fires after TMO cycles in RD_DRAIN.
        s_address = ADDR_W'($urandom); s_burstcount = 8'd8; s_read = 1'b1;
        pass_cyc();
        s_read = 1'b0; rst_req = 1'b1;
        tick();
        repeat (TMO - 1) tick();
        chk("t5_before_timeout", timeout_err, 1'b0);
        chk("t5_before_idle", idle, 1'b0);
        chk("t5_before_out", out_beats, 8);
        tick();
        chk("t5_timeout", timeout_err, 1'b1);
        chk("t5_halt", idle, 1'b1);
        chk("t5_out_zero", out_beats, 0);
        rst_req = 1'b0;
        tick();
        chk("t5_pass_again", idle, 1'b0);
        chk("t5_sticky", timeout_err, 1'b1);

        // Reset in the middle of a write flush.
        mdl_out = 0; mdl_wr = 0;
        s_address = ADDR_W'($urandom); s_burstcount = 8'd16; s_write = 1'b1;
        repeat (3) pass_cyc();
        s_write = 1'b0; rst_req = 1'b1;
        tick();
        tick();
        settle();
        chk("t6_flushing", m_write, 1'b1);
        chk("t6_flush_be", m_byteenable, 0);
        reset_n = 1'b0; rst_req = 1'b0;
        tick();
        reset_n = 1'b1;
        settle();
        chk("t6_idle", idle, 1'b0);
        chk("t6_timeout", timeout_err, 1'b0);
        chk("t6_m_write", m_write, 1'b0);
        chk("t6_m_read", m_read, 1'b0);
        chk("t6_s_rdv", s_readdatavalid, 1'b0);
        chk("t6_out", out_beats, 0);
        chk("t6_s_wait", s_waitrequest, 1'b0);
        rst_req = 1'b1;
        tick();
        settle();
        chk("t6_no_flush_left", m_write, 1'b0);
        chk("t6_direct_halt", idle, 1'b1);
        rst_req = 1'b0;
        tick();
        chk("t6_pass_again", idle, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
